ext_b_arbiter_ipa: RTL and testbench
====================================

# ext_b_arbiter_ipa

Round-robin arbiter that merges N AXI write-response (B) channels from the extension-unit slaves onto one registered B master port toward the interconnect. Each slave keeps its own valid/ready handshake; one response is granted per cycle and captured in a single output register, which gives full throughput with one cycle of latency. The block sits on the return path between the per-slave B buffers and the shared upstream B port.

## Interface
- N_SLAVES, 4, number of requesting slave B channels (2..16)
- ID_WIDTH, 4, AXI ID width
- USER_WIDTH, 6, AXI user width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- slave_valid_i  in  N_SLAVES  per-slave response valid
- slave_resp_i  in  2*N_SLAVES  per-slave BRESP, slave i at [2i+1:2i]
- slave_id_i  in  ID_WIDTH*N_SLAVES  per-slave BID, packed like resp
- slave_user_i  in  USER_WIDTH*N_SLAVES  per-slave BUSER, packed like resp
- slave_ready_o  out  N_SLAVES  per-slave ready; at most one bit high per cycle
- master_valid_o  out  1  registered response valid
- master_resp_o  out  2  registered BRESP
- master_id_o  out  ID_WIDTH  registered BID
- master_user_o  out  USER_WIDTH  registered BUSER
- master_ready_i  in  1  upstream ready
- err_cnt_o  out  16  error-response count (only with EXT_B_ARB_ERRCNT_EN)
- err_cnt_clr_i  in  1  synchronous counter clear (only with EXT_B_ARB_ERRCNT_EN)

Clocking: one clock; reset is asynchronous and active-low (clk_i, rst_ni).

## Operation
- Output register: master_valid_o, master_resp_o, master_id_o, master_user_o.
- load = (|slave_valid_i) && (!master_valid_o || master_ready_i).
- Winner: first index i with slave_valid_i[i], scanning upward from rr_ptr and wrapping from N_SLAVES-1 to 0.
- slave_ready_o[winner] = load; all other bits 0. Combinational from slave_valid_i, master_valid_o, master_ready_i, rr_ptr.
- On load: output register takes the winner's resp/id/user; master_valid_o=1; rr_ptr = winner+1, wrapping from N_SLAVES-1 to 0.
- If master_valid_o && master_ready_i && !(|slave_valid_i): master_valid_o=0.
- If master_valid_o && !master_ready_i: output register and rr_ptr hold; master payload is stable (AXI rule); all slave_ready_o = 0.
- rr_ptr changes only on load.
- Requests may appear or withdraw on any cycle; arbitration is re-evaluated every cycle. The block does not require slaves to hold valid, because no grant is latched across cycles.
- No reordering within a slave; interleaving across slaves is arbitrary per AXI B rules.

## Timing
- Reset (async assert, sync-safe deassert): master_valid_o=0, master_resp_o=0, master_id_o=0, master_user_o=0, rr_ptr=0, err_cnt_o=0.
- Latency: slave handshake in cycle t -> master_valid_o high from t+1.
- Throughput: one response per cycle while master_ready_i=1.
- Simultaneous drain and load in the same cycle: new data replaces old with no bubble.
- Reset mid-transfer: the registered response is discarded; slaves see ready=0 while rst_ni=0.
- N_SLAVES=2..16: rr_ptr width is $clog2(N_SLAVES); pointer increment wraps at N_SLAVES, not at a power of two.

## Configuration
- EXT_B_ARB_ERRCNT_EN defined: the err_cnt_o and err_cnt_clr_i ports exist.
  - Counter increments by 1 on each master handshake (master_valid_o && master_ready_i) with master_resp_o[1]=1 (SLVERR or DECERR).
  - Counter saturates at 16'hFFFF.
  - err_cnt_clr_i has priority over increment; counter reads 0 the next cycle.
- Macro undefined: both ports absent; no counter logic.

## Test plan
- Single slave: slave 2 valid, resp=2'b00, id=4'h5 with master_ready_i=1 -> slave_ready_o=4'b0100 in cycle t; master_valid_o=1, id=4'h5 in t+1; rr_ptr=3.
- All four slaves valid continuously, master_ready_i=1, from reset -> grants 0,1,2,3,0,...; one master beat per cycle, no bubbles.
- Backpressure: master_ready_i=0 for 5 cycles while slaves 1 and 3 are valid -> master payload constant, slave_ready_o=0 throughout; on release, slave 1 then slave 3 are served (given rr_ptr=1).
- Valid withdrawn: slave 0 drops valid before being granted -> slave 1 wins the next load; no response from slave 0 is forwarded.
- Async reset asserted while master_valid_o=1 -> all outputs 0 immediately; after release, the first grant goes to the lowest-index valid slave.
- Error counter (macro on): 3 handshakes with resp 2'b10, 2'b11, 2'b00 -> err_cnt_o=2. Then err_cnt_clr_i pulse in the same cycle as a 2'b10 handshake -> err_cnt_o=0. Counter preloaded to FFFF plus one error -> stays FFFF.

Source files
------------

// File: rtl/ext_b_arbiter_ipa.sv
// Round-robin merge of N AXI B channels into one registered B port.
// Optional error counter: define EXT_B_ARB_ERRCNT_EN.
module ext_b_arbiter_ipa #(
  parameter int N_SLAVES   = 4,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_SLAVES-1:0]            slave_valid_i,
  input  logic [2*N_SLAVES-1:0]          slave_resp_i,
  input  logic [ID_WIDTH*N_SLAVES-1:0]   slave_id_i,
  input  logic [USER_WIDTH*N_SLAVES-1:0] slave_user_i,
  output logic [N_SLAVES-1:0]            slave_ready_o,
  output logic                           master_valid_o,
  output logic [1:0]                     master_resp_o,
  output logic [ID_WIDTH-1:0]            master_id_o,
  output logic [USER_WIDTH-1:0]          master_user_o,
`ifdef EXT_B_ARB_ERRCNT_EN
  output logic [15:0]                    err_cnt_o,
  input  logic                           err_cnt_clr_i,
`endif
  input  logic                           master_ready_i
);

  localparam int PW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_SLAVES - 1);

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         winner;
  logic                  found;
  logic                  load;
  logic [PW-1:0]         ptr_next;
  logic [1:0]            win_resp;
  logic [ID_WIDTH-1:0]   win_id;
  logic [USER_WIDTH-1:0] win_user;

  // Scan upward from rr_ptr with wrap; first valid slave wins.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_SLAVES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SLAVES) idx = idx - N_SLAVES;
      if (!found && slave_valid_i[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // Load whenever the output register is empty or draining; never in reset.
  assign load = found && rst_ni &&
                (!master_valid_o || master_ready_i);

  // One-hot ready to the winning slave only.
  always_comb begin
    slave_ready_o = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      slave_ready_o[i] = load && (winner == PW'(i));
    end
  end

  // Winner payload and the wrapped pointer that follows it.
  always_comb begin
    win_resp = slave_resp_i[2*int'(winner) +: 2];
    win_id   = slave_id_i[ID_WIDTH*int'(winner) +: ID_WIDTH];
    win_user = slave_user_i[USER_WIDTH*int'(winner) +: USER_WIDTH];
    ptr_next = (winner == LAST) ? '0 : winner + 1'b1;
  end

  // Output register: replace on load, clear on drain with no new request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      master_valid_o <= 1'b0;
      master_resp_o  <= '0;
      master_id_o    <= '0;
      master_user_o  <= '0;
    end else if (load) begin
      master_valid_o <= 1'b1;
      master_resp_o  <= win_resp;
      master_id_o    <= win_id;
      master_user_o  <= win_user;
    end else if (master_valid_o && master_ready_i) begin
      master_valid_o <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner only when a grant is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= ptr_next;
    end
  end

`ifdef EXT_B_ARB_ERRCNT_EN
  logic err_hs;

  assign err_hs = master_valid_o && master_ready_i && master_resp_o[1];

  // Saturating count of SLVERR/DECERR beats; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (err_cnt_clr_i) begin
      err_cnt_o <= '0;
    end else if (err_hs && (err_cnt_o != 16'hFFFF)) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_b_arbiter_ipa.sv
// Directed self-checking bench for ext_b_arbiter_ipa (N=4).
// Error-counter scenario runs when EXT_B_ARB_ERRCNT_EN is defined.
module tb_ext_b_arbiter_ipa;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int UW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    slave_valid;
  logic [2*N-1:0]  slave_resp;
  logic [IW*N-1:0] slave_id;
  logic [UW*N-1:0] slave_user;
  logic [N-1:0]    slave_ready;
  logic            master_valid;
  logic [1:0]      master_resp;
  logic [IW-1:0]   master_id;
  logic [UW-1:0]   master_user;
  logic            master_ready;
`ifdef EXT_B_ARB_ERRCNT_EN
  logic [15:0]     err_cnt;
  logic            err_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ext_b_arbiter_ipa #(
    .N_SLAVES(N), .ID_WIDTH(IW), .USER_WIDTH(UW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .slave_valid_i(slave_valid),
    .slave_resp_i(slave_resp),
    .slave_id_i(slave_id),
    .slave_user_i(slave_user),
    .slave_ready_o(slave_ready),
    .master_valid_o(master_valid),
    .master_resp_o(master_resp),
    .master_id_o(master_id),
    .master_user_o(master_user),
`ifdef EXT_B_ARB_ERRCNT_EN
    .err_cnt_o(err_cnt),
    .err_cnt_clr_i(err_clr),
`endif
    .master_ready_i(master_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_slave(input int i, input logic v,
                           input logic [1:0] r,
                           input logic [IW-1:0] id,
                           input logic [UW-1:0] u);
    slave_valid[i]       = v;
    slave_resp[2*i +: 2] = r;
    slave_id[IW*i +: IW] = id;
    slave_user[UW*i +: UW] = u;
  endtask

  task automatic clear_slaves;
    slave_valid = '0;
    slave_resp  = '0;
    slave_id    = '0;
    slave_user  = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_slaves();
    master_ready = 1'b0;
`ifdef EXT_B_ARB_ERRCNT_EN
    err_clr = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_slaves();
    master_ready = 1'b1;
`ifdef EXT_B_ARB_ERRCNT_EN
    err_clr = 1'b0;
`endif
    set_slave(0, 1'b1, 2'b10, 4'h3, 6'h3);
    tick();
    tick();
    checks++;
    if (master_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", master_valid);
    end
    checks++;
    if ({master_resp, master_id, master_user} !== '0) begin
      errors++;
      $display("FAIL reset_payload got %h/%h/%h want 0",
               master_resp, master_id, master_user);
    end
    checks++;
    if (slave_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b want 0000", slave_ready);
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr);
    end
`ifdef EXT_B_ARB_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_errcnt got %h want 0", err_cnt);
    end
`endif
    clear_slaves();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    master_ready = 1'b1;
    set_slave(2, 1'b1, 2'b00, 4'h5, 6'h15);
    #1;
    checks++;
    if (slave_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b want 0100", slave_ready);
    end
    tick();
    clear_slaves();
    checks++;
    if (master_valid !== 1'b1 || master_id !== 4'h5 ||
        master_resp !== 2'b00 || master_user !== 6'h15) begin
      errors++;
      $display("FAIL single_beat got v%b id%h r%b u%h want v1 id5 r00 u15",
               master_valid, master_id, master_resp, master_user);
    end
    checks++;
    if (dut.rr_ptr !== 2'd3) begin
      errors++; $display("FAIL single_ptr got %0d want 3", dut.rr_ptr);
    end
    tick();
    checks++;
    if (master_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got %b want 0", master_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp;
    do_reset();
    master_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_slave(i, 1'b1, 2'b01, IW'(8 + i), UW'(i));
    for (int c = 0; c < 8; c++) begin
      exp = '0;
      exp[c % N] = 1'b1;
      #1;
      checks++;
      if (slave_ready !== exp) begin
        errors++;
        $display("FAIL rr_ready cyc%0d got %b want %b", c, slave_ready, exp);
      end
      tick();
      checks++;
      if (master_valid !== 1'b1 || master_id !== IW'(8 + (c % N))) begin
        errors++;
        $display("FAIL rr_beat cyc%0d got v%b id%h want v1 id%h",
                 c, master_valid, master_id, IW'(8 + (c % N)));
      end
    end
    clear_slaves();
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    master_ready = 1'b1;
    set_slave(0, 1'b1, 2'b00, 4'hA, 6'h01);
    #1;
    tick();
    clear_slaves();
    master_ready = 1'b0;
    set_slave(1, 1'b1, 2'b00, 4'h1, 6'h02);
    set_slave(3, 1'b1, 2'b00, 4'h3, 6'h03);
    checks++;
    if (dut.rr_ptr !== 2'd1) begin
      errors++; $display("FAIL bp_ptr got %0d want 1", dut.rr_ptr);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (slave_ready !== 4'b0000 || master_valid !== 1'b1 ||
          master_id !== 4'hA || master_user !== 6'h01) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got rdy%b v%b id%h u%h want 0000 1 a 01",
                 c, slave_ready, master_valid, master_id, master_user);
      end
      tick();
    end
    master_ready = 1'b1;
    #1;
    checks++;
    if (slave_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_rel1 got %b want 0010", slave_ready);
    end
    tick();
    set_slave(1, 1'b0, 2'b00, 4'h0, 6'h00);
    checks++;
    if (master_id !== 4'h1) begin
      errors++; $display("FAIL bp_beat1 got %h want 1", master_id);
    end
    #1;
    checks++;
    if (slave_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_rel3 got %b want 1000", slave_ready);
    end
    tick();
    clear_slaves();
    checks++;
    if (master_id !== 4'h3 || master_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_beat3 got v%b id%h want v1 id3", master_valid, master_id);
    end
    tick();
    checks++;
    if (master_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got %b want 0", master_valid);
    end
  endtask

  task automatic test_withdraw;
    do_reset();
    master_ready = 1'b1;
    set_slave(3, 1'b1, 2'b00, 4'h7, 6'h07);
    #1;
    tick();
    clear_slaves();
    master_ready = 1'b0;
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      errors++; $display("FAIL wd_wrap got %0d want 0", dut.rr_ptr);
    end
    set_slave(0, 1'b1, 2'b00, 4'hC, 6'h0C);
    set_slave(1, 1'b1, 2'b00, 4'hD, 6'h0D);
    #1;
    checks++;
    if (slave_ready !== 4'b0000) begin
      errors++; $display("FAIL wd_stall got %b want 0000", slave_ready);
    end
    tick();
    set_slave(0, 1'b0, 2'b00, 4'h0, 6'h00);
    tick();
    master_ready = 1'b1;
    #1;
    checks++;
    if (slave_ready !== 4'b0010) begin
      errors++; $display("FAIL wd_ready got %b want 0010", slave_ready);
    end
    tick();
    clear_slaves();
    checks++;
    if (master_id !== 4'hD || master_user !== 6'h0D) begin
      errors++;
      $display("FAIL wd_beat got id%h u%h want idd u0d", master_id, master_user);
    end
    checks++;
    if (dut.rr_ptr !== 2'd2) begin
      errors++; $display("FAIL wd_ptr got %0d want 2", dut.rr_ptr);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    master_ready = 1'b0;
    set_slave(1, 1'b1, 2'b00, 4'h6, 6'h06);
    #1;
    tick();
    clear_slaves();
    set_slave(2, 1'b1, 2'b00, 4'h9, 6'h09);
    set_slave(3, 1'b1, 2'b00, 4'hB, 6'h0B);
    checks++;
    if (master_valid !== 1'b1 || master_id !== 4'h6) begin
      errors++;
      $display("FAIL rm_pre got v%b id%h want v1 id6", master_valid, master_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (master_valid !== 1'b0 || master_id !== 4'h0 ||
        slave_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rm_async got v%b id%h rdy%b want 0 0 0000",
               master_valid, master_id, slave_ready);
    end
    tick();
    rst_n = 1'b1;
    master_ready = 1'b1;
    #1;
    checks++;
    if (slave_ready !== 4'b0100) begin
      errors++; $display("FAIL rm_first got %b want 0100", slave_ready);
    end
    tick();
    clear_slaves();
    checks++;
    if (master_id !== 4'h9) begin
      errors++; $display("FAIL rm_beat got %h want 9", master_id);
    end
    tick();
  endtask

`ifdef EXT_B_ARB_ERRCNT_EN
  task automatic test_errcnt;
    do_reset();
    master_ready = 1'b1;
    set_slave(0, 1'b1, 2'b10, 4'h1, 6'h00);
    tick();
    set_slave(0, 1'b1, 2'b11, 4'h1, 6'h00);
    tick();
    set_slave(0, 1'b1, 2'b00, 4'h1, 6'h00);
    tick();
    clear_slaves();
    tick();
    checks++;
    if (err_cnt !== 16'd2) begin
      errors++; $display("FAIL ec_count got %0d want 2", err_cnt);
    end
    set_slave(0, 1'b1, 2'b10, 4'h1, 6'h00);
    tick();
    clear_slaves();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++; $display("FAIL ec_clear got %0d want 0", err_cnt);
    end
    set_slave(0, 1'b1, 2'b11, 4'h1, 6'h00);
    repeat (65540) tick();
    checks++;
    if (err_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL ec_sat got %h want ffff", err_cnt);
    end
    clear_slaves();
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    clear_slaves();
    master_ready = 1'b0;
`ifdef EXT_B_ARB_ERRCNT_EN
    err_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_reset_mid();
`ifdef EXT_B_ARB_ERRCNT_EN
    test_errcnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
